// File: rtl/dehaze_out_framer.sv
// Dehaze pass-2 output framer: buffers restored pixels in a small FIFO
// and emits them as an AXI4-Stream frame with TLAST and a done pulse.
module dehaze_out_framer #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        enable,
  input  logic [23:0] s_pix_data,
  input  logic        s_pix_valid,
  output logic        s_pix_ready,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic        M_AXIS_TLAST,
  output logic        o_intr,
  output logic        o_busy
);

  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] pix_cnt;
  logic          wr;
  logic          rd;
  logic          is_last;

  // Reset is folded in so the upstream never sees ready while held in reset.
  assign s_pix_ready = ARESETn & enable
                     & (count < (AW+1)'(FIFO_DEPTH))
                     & (state != DONE);

  assign wr      = s_pix_valid & s_pix_ready;
  assign rd      = M_AXIS_TVALID & M_AXIS_TREADY;
  assign is_last = (pix_cnt == CW'(TOTAL - 1));

  assign M_AXIS_TVALID = (count != '0);
  assign M_AXIS_TLAST  = M_AXIS_TVALID & is_last;
  assign M_AXIS_TDATA  = M_AXIS_TVALID
                       ? {8'h00, mem[rd_ptr]}
                       : 32'h0;

  always_ff @(posedge ACLK) begin
    if (wr) mem[wr_ptr] <= s_pix_data;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr, rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Counter tracks the frame index of the FIFO head entry.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      pix_cnt <= '0;
    end else if (rd) begin
      pix_cnt <= is_last ? '0 : pix_cnt + CW'(1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    o_intr   = 1'b0;
    o_busy   = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr) state_nx = STREAM;
      end
      STREAM: begin
        o_busy = 1'b1;
        if (rd && is_last) state_nx = DONE;
      end
      DONE: begin
        o_busy   = 1'b1;
        o_intr   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dehaze_out_framer.sv
// Directed bench for dehaze_out_framer with a 4x2 frame and 4-deep FIFO.
// Transfers are logged on the falling edge and compared to fixed vectors.
module tb_dehaze_out_framer;

  localparam int W = 4;
  localparam int H = 2;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        enable = 1'b1;
  logic [23:0] s_pix_data = '0;
  logic        s_pix_valid = 1'b0;
  logic        s_pix_ready;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY = 1'b0;
  logic        M_AXIS_TLAST;
  logic        o_intr;
  logic        o_busy;

  dehaze_out_framer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .FIFO_DEPTH(4)
  ) dut (
    .ACLK         (ACLK),
    .ARESETn      (ARESETn),
    .enable       (enable),
    .s_pix_data   (s_pix_data),
    .s_pix_valid  (s_pix_valid),
    .s_pix_ready  (s_pix_ready),
    .M_AXIS_TDATA (M_AXIS_TDATA),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TLAST (M_AXIS_TLAST),
    .o_intr       (o_intr),
    .o_busy       (o_busy)
  );

  always #5 ACLK = ~ACLK;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int tl_cyc = -100;
  int intr_cnt = 0;
  int stalls = 0;
  logic [32:0] xq[$];
  logic        stall_p = 1'b0;
  logic [31:0] stall_d;
  logic        stall_l;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        chk("stall_valid", {31'b0, M_AXIS_TVALID}, 32'd1);
        chk("stall_data", M_AXIS_TDATA, stall_d);
        chk("stall_last", {31'b0, M_AXIS_TLAST}, {31'b0, stall_l});
      end
      stall_p = M_AXIS_TVALID & ~M_AXIS_TREADY;
      if (stall_p) begin
        stall_d = M_AXIS_TDATA;
        stall_l = M_AXIS_TLAST;
        stalls++;
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        xq.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
        if (M_AXIS_TLAST) tl_cyc = cyc;
      end
      if (o_intr) begin
        intr_cnt++;
        chk("intr_lat", 32'(cyc - tl_cyc), 32'd1);
      end
    end
  end

  task automatic push(input logic [23:0] d);
    int n;
    n = 0;
    s_pix_data  = d;
    s_pix_valid = 1'b1;
    @(negedge ACLK);
    while (!s_pix_ready && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 200) chk("push_timeout", 32'd0, 32'd1);
    @(posedge ACLK);
    #1;
    s_pix_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic check_frame(input int base, input int n);
    chk("nxfer", 32'(xq.size()), 32'(n));
    for (int i = 0; i < n && i < xq.size(); i++) begin
      chk("tdata", xq[i][31:0], 32'(base + i + 1));
      chk("tlast", {31'b0, xq[i][32]}, {31'b0, (i % 8) == 7});
    end
    xq.delete();
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_ready"}, {31'b0, s_pix_ready}, 32'd0);
    chk({tag, "_tvalid"}, {31'b0, M_AXIS_TVALID}, 32'd0);
    chk({tag, "_tlast"}, {31'b0, M_AXIS_TLAST}, 32'd0);
    chk({tag, "_intr"}, {31'b0, o_intr}, 32'd0);
    chk({tag, "_busy"}, {31'b0, o_busy}, 32'd0);
    chk({tag, "_tdata"}, M_AXIS_TDATA, 32'd0);
  endtask

  initial begin
    int acc;
    int k;
    int s0;

    #1;
    chk_idle_outs("rst");
    wait_cyc(3);
    ARESETn = 1'b1;
    #1;
    chk("post_rst_ready", {31'b0, s_pix_ready}, 32'd1);
    chk("post_rst_busy", {31'b0, o_busy}, 32'd0);

    // back-to-back frame with free-running downstream
    M_AXIS_TREADY = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push(24'(i));
      if (i == 1) chk("busy_mid", {31'b0, o_busy}, 32'd1);
    end
    wait_cyc(5);
    check_frame(0, 8);
    chk("intr_f1", 32'(intr_cnt), 32'd1);
    chk("busy_end", {31'b0, o_busy}, 32'd0);

    // full FIFO back-pressure
    M_AXIS_TREADY = 1'b0;
    acc = 0;
    k = 0;
    repeat (6) begin
      s_pix_data  = 24'(32'h11 + k);
      s_pix_valid = 1'b1;
      @(negedge ACLK);
      if (s_pix_ready) begin
        acc++;
        k++;
      end
      @(posedge ACLK);
      #1;
    end
    s_pix_valid = 1'b0;
    chk("full_acc", 32'(acc), 32'd4);
    chk("full_ready", {31'b0, s_pix_ready}, 32'd0);
    chk("full_tvalid", {31'b0, M_AXIS_TVALID}, 32'd1);
    chk("full_head", M_AXIS_TDATA, 32'h11);
    wait_cyc(3);
    M_AXIS_TREADY = 1'b1;
    for (int i = 5; i <= 8; i++) push(24'(32'h10 + i));
    wait_cyc(6);
    check_frame(32'h10, 8);
    chk("intr_f2", 32'(intr_cnt), 32'd2);

    // downstream toggling every cycle
    s0 = stalls;
    fork
      begin
        for (int i = 1; i <= 8; i++) push(24'(32'h20 + i));
      end
      begin
        repeat (40) begin
          @(posedge ACLK);
          #1;
          M_AXIS_TREADY = ~M_AXIS_TREADY;
        end
      end
    join
    M_AXIS_TREADY = 1'b1;
    wait_cyc(4);
    chk("toggle_stalled", {31'b0, stalls > s0}, 32'd1);
    check_frame(32'h20, 8);
    chk("intr_f3", 32'(intr_cnt), 32'd3);

    // enable drop mid-frame
    for (int i = 1; i <= 3; i++) push(24'(32'h30 + i));
    enable = 1'b0;
    wait_cyc(10);
    chk("en_drain_tvalid", {31'b0, M_AXIS_TVALID}, 32'd0);
    chk("en_ready", {31'b0, s_pix_ready}, 32'd0);
    chk("en_busy", {31'b0, o_busy}, 32'd1);
    chk("en_nxfer", 32'(xq.size()), 32'd3);
    enable = 1'b1;
    for (int i = 4; i <= 8; i++) push(24'(32'h30 + i));
    wait_cyc(5);
    check_frame(32'h30, 8);
    chk("intr_f4", 32'(intr_cnt), 32'd4);

    // reset mid-frame with pixels still buffered
    for (int i = 1; i <= 3; i++) push(24'(32'h40 + i));
    M_AXIS_TREADY = 1'b0;
    push(24'h44);
    push(24'h45);
    chk("pre_rst_tvalid", {31'b0, M_AXIS_TVALID}, 32'd1);
    chk("pre_rst_busy", {31'b0, o_busy}, 32'd1);
    ARESETn = 1'b0;
    #1;
    chk_idle_outs("midrst");
    @(negedge ACLK);
    xq.delete();
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    M_AXIS_TREADY = 1'b1;
    for (int i = 1; i <= 8; i++) push(24'(32'h50 + i));
    wait_cyc(5);
    check_frame(32'h50, 8);
    chk("intr_f5", 32'(intr_cnt), 32'd5);

    // two frames offered back to back
    for (int i = 1; i <= 16; i++) push(24'(32'h60 + i));
    wait_cyc(6);
    check_frame(32'h60, 16);
    chk("intr_f67", 32'(intr_cnt), 32'd7);
    chk("final_busy", {31'b0, o_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
